// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port integer register file.
// Imported by the register file top and its scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NWR_MAX   = 4;

    // Highest-index set bit of a write-hit mask: {found, index}.
    function automatic logic [2:0] hi_sel(input logic [NWR_MAX-1:0] hit);
        logic [2:0] sel;
        sel = '0;
        for (int j = 0; j < NWR_MAX; j++) begin
            if (hit[j]) sel = {1'b1, 2'(j)};
        end
        return sel;
    endfunction

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy bits for RAW/WAW stall detection.
// A same-cycle alloc beats a writeback clear.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
        end
        if (alloc_en) busy_nxt[alloc_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-to-read bypass
// and a busy scoreboard for decode hazard stalls.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0] mem [NREGS];

    // Later ports are applied last, so the highest index wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                    mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .busy_vec   (busy_vec)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]      ra;
        logic [NWR_MAX-1:0] hit;
        logic [2:0]         sel;
        logic [XLEN-1:0]    data;

        assign ra = rd_addr[i*AW +: AW];

        always_comb begin
            hit = '0;
            for (int j = 0; j < NWR; j++) begin
                hit[j] = wr_en[j] && (wr_addr[j*AW +: AW] == ra);
            end
            sel  = hi_sel(hit);
            data = mem[ra];
            if (sel[2]) begin
                for (int j = 0; j < NWR; j++) begin
                    if (int'(sel[1:0]) == j) data = wr_data[j*XLEN +: XLEN];
                end
            end
            if (ra == '0) data = '0;
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_busy[i] = busy_vec[ra] & ~sel[2] & (ra != '0);
    end

endmodule
